// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: control-word geometry and the saturating helpers
// used by the loop filter.
//   CTRL_W       : width of the sign-magnitude VCO control word
//   CTRL_MAG_MAX : largest magnitude the control word can carry
//   clamp_sym    : clamp a signed value to [-lim, +lim]
//   sat_add      : a + b, clamped to [-lim, +lim]
//   sm_encode    : signed value (already within +-CTRL_MAG_MAX) -> {mag, sign}
package dpll_pkg;

  localparam int CTRL_W       = 13;
  localparam int CTRL_MAG_MAX = 4095;

  function automatic logic signed [31:0] clamp_sym(input logic signed [31:0] v,
                                                   input logic signed [31:0] lim);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input logic signed [31:0] lim);
    return clamp_sym(a + b, lim);
  endfunction

  // Sign bit is 1 for sum >= 0, so a zero sum encodes as 13'h0001.
  function automatic logic [CTRL_W-1:0] sm_encode(input logic signed [31:0] sum);
    logic [31:0] mag;
    mag = (sum < 0) ? $unsigned(-sum) : $unsigned(sum);
    return {mag[CTRL_W-2:0], (sum >= 0)};
  endfunction

endpackage

// File: rtl/pi_accumulator.sv
// Integrator of the PI loop filter with freeze and anti-windup clamp.
// Ports:
//   clk_ref  : clock, rising edge
//   rst      : synchronous active-high reset, clears the integrator
//   en_i     : phase-error sample valid
//   freeze_i : hold the integrator on a valid sample
//   err_i    : signed phase error
//   acc_o    : integrator value, always within +-(CTRL_MAG_MAX << KI_SHIFT)
module pi_accumulator
  import dpll_pkg::*;
#(
  parameter int ERR_W    = 8,
  parameter int ACC_W    = 20,
  parameter int KI_SHIFT = 6
) (
  input  logic                    clk_ref,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    freeze_i,
  input  logic signed [ERR_W-1:0] err_i,
  output logic signed [ACC_W-1:0] acc_o
);

  // The clamp limit is chosen so that acc >>> KI_SHIFT never exceeds the
  // control-word magnitude; the accumulator can therefore never wrap.
  localparam int ACC_LIM = CTRL_MAG_MAX << KI_SHIFT;

  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i && !freeze_i) begin
      acc_d = ACC_W'(sat_add(32'(acc_q), 32'(err_i), ACC_LIM));
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/vco_ctrl_loop_filter.sv
// PI loop filter producing the sign-magnitude VCO control word, plus a lock
// detector driven by a run of small phase errors.
// Ports:
//   clk_ref              : clock, rising edge
//   rst                  : synchronous active-high reset
//   phase_err            : signed phase error (positive = VCO too slow)
//   phase_err_valid      : phase_err is sampled on this edge
//   freeze               : integrator holds on a sampling edge
//   vco_dig_ctrl_voltage : {magnitude[11:0], sign}, sign 1 raises frequency
//   ctrl_valid           : one-cycle pulse when the control word updates
//   locked               : lock indication
module vco_ctrl_loop_filter
  import dpll_pkg::*;
#(
  parameter int ERR_W    = 8,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 6,
  parameter int ACC_W    = 20,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                    clk_ref,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] phase_err,
  input  logic                    phase_err_valid,
  input  logic                    freeze,
  output logic [CTRL_W-1:0]       vco_dig_ctrl_voltage,
  output logic                    ctrl_valid,
  output logic                    locked
);

  localparam int P_W   = ERR_W + KP_SHIFT;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    v1_q, v1_d;
  logic [CTRL_W-1:0]       word_q, word_d;
  logic                    cval_q, cval_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    locked_q, locked_d;

  logic signed [ACC_W-1:0] i_term;
  logic signed [ACC_W:0]   sum;
  logic signed [31:0]      sum_c;
  logic signed [ERR_W:0]   err_x;
  logic [ERR_W:0]          abs_err;
  logic                    in_tol;

  pi_accumulator #(
    .ERR_W    (ERR_W),
    .ACC_W    (ACC_W),
    .KI_SHIFT (KI_SHIFT)
  ) u_acc (
    .clk_ref  (clk_ref),
    .rst      (rst),
    .en_i     (phase_err_valid),
    .freeze_i (freeze),
    .err_i    (phase_err),
    .acc_o    (acc)
  );

  always_comb begin
    // Stage 1: proportional term registered alongside the integrator update.
    p_d  = p_q;
    v1_d = phase_err_valid;
    if (phase_err_valid) begin
      p_d = P_W'(phase_err) <<< KP_SHIFT;
    end

    // Stage 2: acc already holds the update made by the same sample.
    i_term = acc >>> KI_SHIFT;
    sum    = (ACC_W+1)'(p_q) + (ACC_W+1)'(i_term);
    sum_c  = clamp_sym(32'(sum), CTRL_MAG_MAX);
    word_d = word_q;
    cval_d = 1'b0;
    if (v1_q) begin
      word_d = sm_encode(sum_c);
      cval_d = 1'b1;
    end

    // One extra bit so |-2^(ERR_W-1)| is representable.
    err_x   = (ERR_W+1)'(phase_err);
    abs_err = (err_x < 0) ? $unsigned(-err_x) : $unsigned(err_x);
    in_tol  = (abs_err <= (ERR_W+1)'(LOCK_TOL));

    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (phase_err_valid) begin
      if (in_tol) begin
        if (cnt_q != CNT_W'(LOCK_CNT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(LOCK_CNT)) begin
          locked_d = 1'b1;
        end
      end else begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      p_q      <= '0;
      v1_q     <= 1'b0;
      word_q   <= '0;
      cval_q   <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      v1_q     <= v1_d;
      word_q   <= word_d;
      cval_q   <= cval_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign vco_dig_ctrl_voltage = word_q;
  assign ctrl_valid           = cval_q;
  assign locked               = locked_q;

endmodule

// File: tb/tb_vco_ctrl_loop_filter.sv
module tb_vco_ctrl_loop_filter;

  logic              clk_ref = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] phase_err = '0;
  logic              phase_err_valid = 1'b0;
  logic              freeze = 1'b0;
  logic [12:0]       vco_dig_ctrl_voltage;
  logic              ctrl_valid;
  logic              locked;

  vco_ctrl_loop_filter dut (
    .clk_ref              (clk_ref),
    .rst                  (rst),
    .phase_err            (phase_err),
    .phase_err_valid      (phase_err_valid),
    .freeze               (freeze),
    .vco_dig_ctrl_voltage (vco_dig_ctrl_voltage),
    .ctrl_valid           (ctrl_valid),
    .locked               (locked)
  );

  always #5 clk_ref = ~clk_ref;

  int cyc = 0;
  always @(posedge clk_ref) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [12:0] word;
    int          due;
  } sb_t;
  sb_t exp_q[$];
  sb_t sb_item;

  typedef struct {
    int          err;
    logic        frz;
    logic [12:0] exp_word;
  } vec_t;
  vec_t vecs[8];

  // Reference model state
  int          acc_m;
  int          cnt_m;
  logic        locked_m;
  logic [12:0] last_word_m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Scoreboard: every ctrl_valid pulse must match the oldest pending sample,
  // at exactly the edge it is due.
  always @(negedge clk_ref) begin
    if (ctrl_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_ctrl_valid", 1, 0);
      end else begin
        sb_item = exp_q.pop_front();
        check("sb_word", vco_dig_ctrl_voltage, sb_item.word);
        check("sb_latency", cyc, sb_item.due);
        $display("txn cyc=%0d word=0x%04h expected=0x%04h", cyc,
                 vco_dig_ctrl_voltage, sb_item.word);
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("missing_ctrl_valid", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  // Called just after a falling edge; sample is captured at the next rising edge.
  task automatic drive(input int e, input logic frz);
    int p, i, s, ae;
    phase_err       = 8'(e);
    phase_err_valid = 1'b1;
    freeze          = frz;
    if (!frz) begin
      acc_m = acc_m + e;
      if (acc_m > 262080) acc_m = 262080;
      if (acc_m < -262080) acc_m = -262080;
    end
    p = e * 4;
    if (acc_m >= 0) i = acc_m / 64;
    else            i = -((-acc_m + 63) / 64);
    s = p + i;
    if (s > 4095)  s = 4095;
    if (s < -4095) s = -4095;
    last_word_m = (s >= 0) ? 13'(s * 2 + 1) : 13'((-s) * 2);
    ae = (e < 0) ? -e : e;
    if (ae <= 2) begin
      if (cnt_m < 16) cnt_m = cnt_m + 1;
      if (cnt_m == 16) locked_m = 1'b1;
    end else begin
      cnt_m    = 0;
      locked_m = 1'b0;
    end
    exp_q.push_back('{last_word_m, cyc + 2});
    @(negedge clk_ref);
    phase_err_valid = 1'b0;
    freeze          = 1'b0;
    check("locked", locked, locked_m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_ref);
      check("hold_word", vco_dig_ctrl_voltage, last_word_m);
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    phase_err_valid = 1'b0;
    freeze          = 1'b0;
    @(posedge clk_ref);
    #1;
    exp_q.delete();
    acc_m       = 0;
    cnt_m       = 0;
    locked_m    = 1'b0;
    last_word_m = '0;
    @(negedge clk_ref);
    rst = 1'b0;
    check("rst_word", vco_dig_ctrl_voltage, 0);
    check("rst_ctrl_valid", ctrl_valid, 0);
    check("rst_locked", locked, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16,   1'b0, 13'h0081};
    vecs[1] = '{-16,  1'b0, 13'h0082};
    vecs[2] = '{50,   1'b1, 13'h0191};
    vecs[3] = '{0,    1'b0, 13'h0001};
    vecs[4] = '{-128, 1'b0, 13'h0404};
    vecs[5] = '{127,  1'b0, 13'h03FB};
    vecs[6] = '{-1,   1'b0, 13'h000A};
    vecs[7] = '{1,    1'b0, 13'h0009};

    repeat (2) @(negedge clk_ref);
    do_reset();

    // Single samples from reset against hand-computed words
    for (int v = 0; v < 8; v++) begin
      do_reset();
      drive(vecs[v].err, vecs[v].frz);
      idle(1);
      check("vec_word", vco_dig_ctrl_voltage, vecs[v].exp_word);
      idle(2);
    end

    // Anti-windup: saturate, then recover with one negative error
    do_reset();
    for (int k = 0; k < 2064; k++) drive(127, 1'b0);
    idle(1);
    check("windup_sat", vco_dig_ctrl_voltage, 13'h1FFF);
    drive(-128, 1'b0);
    idle(1);
    check("windup_recover", vco_dig_ctrl_voltage, 13'h1BFB);

    // Freeze holds the integrator, release resumes it
    do_reset();
    for (int k = 0; k < 10; k++) drive(50, 1'b1);
    idle(1);
    check("freeze_word", vco_dig_ctrl_voltage, 13'h0191);
    drive(50, 1'b0);
    drive(14, 1'b0);
    idle(1);
    check("freeze_release", vco_dig_ctrl_voltage, 13'h0073);

    // Lock rise at the 16th small error, fall on a large one
    do_reset();
    for (int k = 0; k < 15; k++) drive(1, 1'b0);
    check("lock_not_yet", locked, 0);
    drive(1, 1'b0);
    check("lock_rise", locked, 1);
    drive(3, 1'b0);
    check("lock_fall", locked, 0);
    // Tolerance boundary on the negative side
    for (int k = 0; k < 16; k++) drive(-2, 1'b0);
    check("lock_neg_tol", locked, 1);
    drive(-3, 1'b0);
    check("lock_neg_drop", locked, 0);
    // Reset with a sample in flight: its output must never appear
    drive(2, 1'b0);
    do_reset();
    idle(2);

    // Back-to-back bursts separated by 3-cycle gaps
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) drive(int'($urandom_range(255)) - 128, 1'(k == 2));
      idle(3);
    end

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
